// File: rtl/uart_tx_axil_master_pkg.sv
// Shared widths, FSM encodings and AXI4-Lite write payload types for the UART TX master.
package uart_tx_axil_master_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 32;
  localparam int unsigned AXI_STRB_W = AXI_DATA_W / 8;
  localparam int unsigned AXI_PROT_W = 3;
  localparam int unsigned AXI_RESP_W = 2;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_SEND = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP = 2'd2;

  localparam logic [AXI_RESP_W-1:0] RESP_OKAY = 2'b00;

  typedef struct packed {
    logic [AXI_ADDR_W-1:0] addr;
    logic [AXI_PROT_W-1:0] prot;
  } axil_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic [AXI_STRB_W-1:0] strb;
  } axil_w_t;

  // One character lands in the low byte lane of the TX register.
  function automatic axil_w_t tx_beat(input logic [BYTE_W-1:0] b);
    axil_w_t beat;
    beat.data = AXI_DATA_W'(b);
    beat.strb = AXI_STRB_W'(1);
    return beat;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with wrap-bit pointers; full/empty/head are registered,
// next-cycle full/empty are exported for callers that register their own flags.
module byte_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic             full_nxt_c,
  output logic             empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr, rd_ptr, wr_ptr_d, rd_ptr_d;
  logic [WIDTH-1:0] head_d;
  logic             do_push, do_pop;

  always_comb begin
    do_push     = push && !full;
    do_pop      = pop && !empty;
    wr_ptr_d    = wr_ptr + PW'(do_push);
    rd_ptr_d    = rd_ptr + PW'(do_pop);
    empty_nxt_c = (wr_ptr_d == rd_ptr_d);
    full_nxt_c  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    // A push into the slot about to become head must be forwarded, the array
    // write has not landed yet.
    if (do_push && (wr_ptr[AW-1:0] == rd_ptr_d[AW-1:0])) begin
      head_d = push_data;
    end else begin
      head_d = mem[rd_ptr_d[AW-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
      head   <= '0;
    end else begin
      wr_ptr <= wr_ptr_d;
      rd_ptr <= rd_ptr_d;
      full   <= full_nxt_c;
      empty  <= empty_nxt_c;
      head   <= head_d;
    end
  end

endmodule

// File: rtl/uart_tx_axil_master.sv
// Buffers producer bytes and writes each one, in order, to a UART TX register
// over an AXI4-Lite master write channel; the read channel is tied off.
module uart_tx_axil_master
  import uart_tx_axil_master_pkg::*;
#(
  parameter int unsigned           FIFO_DEPTH = 8,
  parameter logic [AXI_ADDR_W-1:0] TX_ADDR    = 32'h0000_0004
) (
  input  logic                  clk,
  input  logic                  rstn,

  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BYTE_W-1:0]     in_data,

  output logic                  m_axilite_awvalid,
  input  logic                  m_axilite_awready,
  output logic [AXI_ADDR_W-1:0] m_axilite_awaddr,
  output logic [AXI_PROT_W-1:0] m_axilite_awprot,

  output logic                  m_axilite_wvalid,
  input  logic                  m_axilite_wready,
  output logic [AXI_DATA_W-1:0] m_axilite_wdata,
  output logic [AXI_STRB_W-1:0] m_axilite_wstrb,

  input  logic                  m_axilite_bvalid,
  output logic                  m_axilite_bready,
  input  logic [AXI_RESP_W-1:0] m_axilite_bresp,

  output logic                  m_axilite_arvalid,
  output logic [AXI_ADDR_W-1:0] m_axilite_araddr,
  output logic [AXI_PROT_W-1:0] m_axilite_arprot,
  output logic                  m_axilite_rready,
  input  logic                  m_axilite_rvalid,
  input  logic [AXI_DATA_W-1:0] m_axilite_rdata,
  input  logic [AXI_RESP_W-1:0] m_axilite_rresp,

  output logic                  busy,
  output logic                  err
);

  logic [STATE_W-1:0] state, state_d;
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic               bready_q, bready_d;
  logic [BYTE_W-1:0]  wbyte_q, wbyte_d;
  logic               err_q, err_d;
  logic               busy_q, in_ready_q;

  logic               fifo_push, fifo_pop;
  logic               fifo_full, fifo_empty;
  logic               fifo_full_nxt, fifo_empty_nxt;
  logic [BYTE_W-1:0]  fifo_head;

  logic               aw_fire, w_fire, b_fire;
  axil_aw_t           aw_beat;
  axil_w_t            w_beat;
  logic               unused_inputs;

  assign fifo_push = in_valid && in_ready_q;
  assign aw_fire   = awvalid_q && m_axilite_awready;
  assign w_fire    = wvalid_q && m_axilite_wready;
  assign b_fire    = bready_q && m_axilite_bvalid;

  byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BYTE_W)
  ) u_fifo (
    .clk         (clk),
    .rstn        (rstn),
    .push        (fifo_push),
    .push_data   (in_data),
    .pop         (fifo_pop),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .head        (fifo_head),
    .full_nxt_c  (fifo_full_nxt),
    .empty_nxt_c (fifo_empty_nxt)
  );

  // Next state and next registered outputs; the head byte stays queued until its response.
  always_comb begin
    state_d   = state;
    awvalid_d = awvalid_q;
    wvalid_d  = wvalid_q;
    bready_d  = bready_q;
    wbyte_d   = wbyte_q;
    err_d     = err_q;
    fifo_pop  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          state_d   = ST_SEND;
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          wbyte_d   = fifo_head;
        end
      end
      ST_SEND: begin
        if (aw_fire) awvalid_d = 1'b0;
        if (w_fire)  wvalid_d  = 1'b0;
        if (!awvalid_d && !wvalid_d) begin
          state_d  = ST_RESP;
          bready_d = 1'b1;
        end
      end
      ST_RESP: begin
        if (b_fire) begin
          fifo_pop = 1'b1;
          err_d    = err_q | (m_axilite_bresp != RESP_OKAY);
          bready_d = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      wbyte_q    <= '0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      state      <= state_d;
      awvalid_q  <= awvalid_d;
      wvalid_q   <= wvalid_d;
      bready_q   <= bready_d;
      wbyte_q    <= wbyte_d;
      err_q      <= err_d;
      busy_q     <= (state_d != ST_IDLE) || !fifo_empty_nxt;
      in_ready_q <= !fifo_full_nxt;
    end
  end

  assign aw_beat = '{addr: TX_ADDR, prot: 3'b000};
  assign w_beat  = tx_beat(wbyte_q);

  assign in_ready          = in_ready_q;
  assign m_axilite_awvalid = awvalid_q;
  assign m_axilite_awaddr  = aw_beat.addr;
  assign m_axilite_awprot  = aw_beat.prot;
  assign m_axilite_wvalid  = wvalid_q;
  assign m_axilite_wdata   = w_beat.data;
  assign m_axilite_wstrb   = w_beat.strb;
  assign m_axilite_bready  = bready_q;
  assign busy              = busy_q;
  assign err               = err_q;

  // Write-only master: read channel is permanently idle.
  assign m_axilite_arvalid = 1'b0;
  assign m_axilite_araddr  = '0;
  assign m_axilite_arprot  = '0;
  assign m_axilite_rready  = 1'b0;

  assign unused_inputs = ^{m_axilite_rvalid, m_axilite_rdata, m_axilite_rresp, fifo_full};

endmodule

// File: tb/tb_uart_tx_axil_master.sv
// Directed bench: table of single-write vectors against a delay-configurable
// AXI4-Lite slave, plus hand sequences for fill, error, streaming and reset.
module tb_uart_tx_axil_master;

  localparam logic [31:0] TX_ADDR = 32'h0000_0004;

  logic        clk = 1'b0;
  logic        rstn;
  logic        in_valid, in_ready;
  logic [7:0]  in_data;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic [1:0]  bresp, rresp;
  logic        arvalid, rready, rvalid;
  logic        busy, err;

  always #5 clk = ~clk;

  uart_tx_axil_master #(.FIFO_DEPTH(8), .TX_ADDR(TX_ADDR)) dut (
    .clk(clk), .rstn(rstn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .m_axilite_awvalid(awvalid), .m_axilite_awready(awready),
    .m_axilite_awaddr(awaddr), .m_axilite_awprot(awprot),
    .m_axilite_wvalid(wvalid), .m_axilite_wready(wready),
    .m_axilite_wdata(wdata), .m_axilite_wstrb(wstrb),
    .m_axilite_bvalid(bvalid), .m_axilite_bready(bready), .m_axilite_bresp(bresp),
    .m_axilite_arvalid(arvalid), .m_axilite_araddr(araddr), .m_axilite_arprot(arprot),
    .m_axilite_rready(rready), .m_axilite_rvalid(rvalid),
    .m_axilite_rdata(rdata), .m_axilite_rresp(rresp),
    .busy(busy), .err(err)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Slave configuration and scoreboard
  int          aw_dly = 0, w_dly = 0, b_dly = 0;
  bit          stall_aw = 1'b0;
  logic [1:0]  resp_q[$];
  logic [31:0] aw_log[$];
  logic [31:0] w_log[$];
  int          n_aw = 0, n_b = 0, viol = 0;

  int          aw_cnt, w_cnt, b_cnt;
  bit          aw_pend, w_pend, b_pend, prev_aw, prev_w;
  logic [31:0] prev_awaddr, prev_wdata;

  // Slave: decides ready/valid on each falling edge and logs the handshakes
  // that will occur on the following rising edge.
  initial begin
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    rvalid = 1'b0; rdata = '0; rresp = 2'b00;
    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    aw_pend = 0; w_pend = 0; b_pend = 0; prev_aw = 0; prev_w = 0;
    prev_awaddr = '0; prev_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
        aw_pend = 0; w_pend = 0; b_pend = 0; prev_aw = 0; prev_w = 0;
      end else begin
        if (prev_aw && !aw_pend && (!awvalid || awaddr != prev_awaddr)) viol++;
        if (prev_w && !w_pend && (!wvalid || wdata != prev_wdata)) viol++;
        if (aw_pend) begin awready = 1'b0; aw_cnt = 0; end
        if (w_pend)  begin wready  = 1'b0; w_cnt  = 0; end
        if (b_pend)  begin bvalid  = 1'b0; bresp = 2'b00; b_cnt = 0; end
        if (awvalid && !awready) begin
          if (aw_cnt >= aw_dly && !stall_aw) awready = 1'b1; else aw_cnt++;
        end
        if (wvalid && !wready) begin
          if (w_cnt >= w_dly) wready = 1'b1; else w_cnt++;
        end
        if (bready && !bvalid) begin
          if (b_cnt >= b_dly) begin
            bvalid = 1'b1;
            bresp  = (resp_q.size() != 0) ? resp_q.pop_front() : 2'b00;
          end else b_cnt++;
        end
        aw_pend = awvalid && awready;
        w_pend  = wvalid && wready;
        b_pend  = bvalid && bready;
        if (aw_pend) begin
          aw_log.push_back(awaddr);
          n_aw++;
          if (awprot != 3'b000) viol++;
        end
        if (w_pend) begin
          w_log.push_back(wdata);
          if (wstrb != 4'b0001) viol++;
        end
        if (b_pend) n_b++;
        prev_aw = awvalid; prev_awaddr = awaddr;
        prev_w  = wvalid;  prev_wdata  = wdata;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_logs();
    aw_log.delete(); w_log.delete(); resp_q.delete();
    n_aw = 0; n_b = 0; viol = 0;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 200) begin tick(); n++; end
    if (!in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL push_timeout: in_ready stuck at 0 for byte %0h", b);
    end
    tick();
  endtask

  task automatic wait_idle(input int max_cyc, input string name);
    int n = 0;
    while (busy && n < max_cyc) begin tick(); n++; end
    tick();
    check(name, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick(); tick();
    rstn = 1'b1;
    tick();
    clear_logs();
  endtask

  typedef struct {
    logic [7:0] data;
    int         aw_dly;
    int         w_dly;
    int         b_dly;
    logic [1:0] resp;
    logic       exp_err;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int errs, seen, base_aw, max_occ, n_pushed, rdy_low;
    logic [31:0] rd_tie;

    vecs[0] = '{8'h41, 0, 0, 0, 2'b00, 1'b0};
    vecs[1] = '{8'h42, 3, 0, 0, 2'b00, 1'b0};
    vecs[2] = '{8'h43, 0, 3, 1, 2'b00, 1'b0};
    vecs[3] = '{8'h7E, 2, 2, 2, 2'b00, 1'b0};
    vecs[4] = '{8'hFF, 5, 1, 0, 2'b00, 1'b0};
    vecs[5] = '{8'h00, 1, 4, 3, 2'b11, 1'b1};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0;
    tick(); tick();
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid",  32'(wvalid),  32'd0);
    check("rst_bready",  32'(bready),  32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_busy",    32'(busy),    32'd0);
    rd_tie = {27'd0, arvalid, rready, arprot} | araddr;
    check("rd_tieoff", rd_tie, 32'd0);
    rstn = 1'b1;
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Latency: byte accepted at edge N gives valids after edge N+1
    clear_logs();
    in_valid = 1'b1; in_data = 8'h5A;
    tick();
    in_valid = 1'b0;
    check("lat_awvalid_n", 32'(awvalid), 32'd0);
    check("lat_busy_n",    32'(busy),    32'd1);
    tick();
    check("lat_valids_n1", {30'd0, awvalid, wvalid}, 32'd3);
    check("lat_awaddr",    awaddr, TX_ADDR);
    check("lat_wdata",     wdata, 32'h0000_005A);
    check("lat_wstrb",     32'(wstrb), 32'd1);
    wait_idle(50, "lat_idle");
    check("lat_n_b", 32'(n_b), 32'd1);

    for (int i = 0; i < 6; i++) begin
      clear_logs();
      aw_dly = vecs[i].aw_dly; w_dly = vecs[i].w_dly; b_dly = vecs[i].b_dly;
      resp_q.push_back(vecs[i].resp);
      push_byte(vecs[i].data);
      in_valid = 1'b0;
      wait_idle(100, $sformatf("vec%0d_idle", i));
      check($sformatf("vec%0d_n_w", i),    32'(w_log.size()), 32'd1);
      check($sformatf("vec%0d_wdata", i),  w_log[0], {24'h0, vecs[i].data});
      check($sformatf("vec%0d_awaddr", i), aw_log[0], TX_ADDR);
      check($sformatf("vec%0d_n_b", i),    32'(n_b), 32'd1);
      check($sformatf("vec%0d_err", i),    32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_stable", i), 32'(viol), 32'd0);
    end
    aw_dly = 0; w_dly = 0; b_dly = 0;

    // Error on the middle of three writes; flag stays set
    do_reset();
    check("err_clear_after_rst", 32'(err), 32'd0);
    resp_q.push_back(2'b00); resp_q.push_back(2'b10); resp_q.push_back(2'b00);
    push_byte(8'h61); push_byte(8'h62); push_byte(8'h63);
    in_valid = 1'b0;
    wait_idle(300, "err3_idle");
    check("err3_err",   32'(err), 32'd1);
    check("err3_n_w",   32'(w_log.size()), 32'd3);
    check("err3_order", {8'h0, w_log[0][7:0], w_log[1][7:0], w_log[2][7:0]}, 32'h0061_6263);
    check("err3_n_b",   32'(n_b), 32'd3);

    // Fill to full with AW stalled; ninth byte waits for the first response
    clear_logs();
    stall_aw = 1'b1;
    for (int i = 0; i < 8; i++) push_byte(8'h30 + 8'(i));
    check("full_in_ready", 32'(in_ready), 32'd0);
    in_data = 8'h38;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (in_ready) seen++;
      tick();
    end
    check("full_held", 32'(seen), 32'd0);
    stall_aw = 1'b0;
    seen = 0;
    while (!in_ready && seen < 100) begin tick(); seen++; end
    check("full_rise_after_b", 32'(n_b), 32'd1);
    tick();
    in_valid = 1'b0;
    wait_idle(500, "full_idle");
    check("full_n_w", 32'(w_log.size()), 32'd9);
    errs = 0;
    for (int i = 0; i < 9; i++) if (w_log[i] != 32'(8'h30 + 8'(i))) errs++;
    check("full_order", 32'(errs), 32'd0);
    check("full_stable", 32'(viol), 32'd0);

    // Streaming one byte every 4 cycles into an always-ready slave
    clear_logs();
    max_occ = 0; n_pushed = 0; rdy_low = 0;
    for (int i = 0; i < 12; i++) begin
      if (!in_ready) rdy_low++;
      in_valid = 1'b1; in_data = 8'hA0 + 8'(i);
      tick();
      in_valid = 1'b0;
      n_pushed++;
      for (int k = 0; k < 4; k++) begin
        if (n_pushed - n_b > max_occ) max_occ = n_pushed - n_b;
        if (k < 3) tick();
      end
    end
    wait_idle(50, "strm_idle");
    check("strm_max_occ", 32'(max_occ), 32'd1);
    check("strm_rdy_low", 32'(rdy_low), 32'd0);
    check("strm_n_w", 32'(w_log.size()), 32'd12);
    errs = 0;
    for (int i = 0; i < 12; i++) if (w_log[i] != 32'(8'hA0 + 8'(i))) errs++;
    check("strm_order", 32'(errs), 32'd0);

    // Reset during RESP with bytes queued
    clear_logs();
    b_dly = 20;
    for (int i = 0; i < 4; i++) push_byte(8'hC0 + 8'(i));
    in_valid = 1'b0;
    seen = 0;
    while (!bready && seen < 50) begin tick(); seen++; end
    check("rstmid_in_resp", 32'(bready), 32'd1);
    rstn = 1'b0;
    #1;
    check("rstmid_valids", {29'd0, awvalid, wvalid, bready}, 32'd0);
    check("rstmid_busy",   32'(busy), 32'd0);
    check("rstmid_err",    32'(err),  32'd0);
    tick(); tick();
    rstn = 1'b1;
    b_dly = 0;
    base_aw = n_aw;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (awvalid || wvalid || bready || busy) seen++;
    end
    check("rstmid_quiet",    32'(seen), 32'd0);
    check("rstmid_no_aw",    32'(n_aw - base_aw), 32'd0);
    check("rstmid_in_ready", 32'(in_ready), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
